// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the CPU run/step/halt controller.
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2,
    ST_HALT = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE   = 2'd0,
    CAUSE_EBREAK = 2'd1,
    CAUSE_BP     = 2'd2,
    CAUSE_EXT    = 2'd3
  } cause_e;

  localparam logic [31:0] EBREAK_OPCODE = 32'h0010_0073;

endpackage

// File: rtl/cpu_halt_detect.sv
// Combinational halt-condition compare: EBREAK opcode match and PC breakpoint match.
module cpu_halt_detect
  import cpu_ctrl_pkg::*;
#(
  parameter int EBREAK_HALT = 1
) (
  input  logic [31:0] pc_i,
  input  logic [31:0] inst_i,
  input  logic        bp_en_i,
  input  logic [31:0] bp_addr_i,
  input  logic        bp_skip_i,
  output logic        is_ebrk_o,
  output logic        is_bp_o
);

  assign is_ebrk_o = (EBREAK_HALT != 0) && (inst_i == EBREAK_OPCODE);
  // bp_skip lets the instruction we halted on run once after resume.
  assign is_bp_o   = bp_en_i && (pc_i == bp_addr_i) && !bp_skip_i;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/step/halt sequencer: gates the datapath enable and counts retired instructions.
module cpu_run_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int EBREAK_HALT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run_i,
  input  logic             step_i,
  input  logic             halt_i,
  input  logic             resume_i,
  input  logic [31:0]      pc_i,
  input  logic [31:0]      inst_i,
  input  logic             bp_en_i,
  input  logic [31:0]      bp_addr_i,
  output logic             cpu_en_o,
  output logic [1:0]       state_o,
  output logic [1:0]       cause_o,
  output logic [CNT_W-1:0] retired_o
);

  state_e           state_q, state_d;
  cause_e           cause_q, cause_d;
  logic             bp_skip_q, bp_skip_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             is_ebrk, is_bp;
  logic             cpu_en;

  cpu_halt_detect #(
    .EBREAK_HALT(EBREAK_HALT)
  ) u_halt_detect (
    .pc_i      (pc_i),
    .inst_i    (inst_i),
    .bp_en_i   (bp_en_i),
    .bp_addr_i (bp_addr_i),
    .bp_skip_i (bp_skip_q),
    .is_ebrk_o (is_ebrk),
    .is_bp_o   (is_bp)
  );

  always_comb begin
    state_d   = state_q;
    cause_d   = cause_q;
    bp_skip_d = bp_skip_q;
    cpu_en    = 1'b0;

    // Halt detection is only consulted in RUN/STEP, where pc_i/inst_i are meaningful.
    unique case (state_q)
      ST_IDLE: begin
        if (run_i)       state_d = ST_RUN;
        else if (step_i) state_d = ST_STEP;
      end
      ST_RUN: begin
        cpu_en = !is_ebrk && !is_bp && !halt_i && run_i;
        if (is_ebrk) begin
          state_d = ST_HALT;
          cause_d = CAUSE_EBREAK;
        end else if (is_bp) begin
          state_d   = ST_HALT;
          cause_d   = CAUSE_BP;
          bp_skip_d = 1'b1;
        end else if (halt_i) begin
          state_d = ST_HALT;
          cause_d = CAUSE_EXT;
        end else if (!run_i) begin
          state_d = ST_IDLE;
        end
      end
      ST_STEP: begin
        cpu_en = !is_ebrk;
        if (is_ebrk) begin
          state_d = ST_HALT;
          cause_d = CAUSE_EBREAK;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HALT: begin
        // An ebreak halt is terminal until reset.
        if (resume_i && (cause_q != CAUSE_EBREAK)) begin
          state_d = ST_IDLE;
          cause_d = CAUSE_NONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (cpu_en) bp_skip_d = 1'b0;
  end

  assign retired_d = retired_q + {{(CNT_W-1){1'b0}}, cpu_en};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      cause_q   <= CAUSE_NONE;
      bp_skip_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      cause_q   <= cause_d;
      bp_skip_q <= bp_skip_d;
      retired_q <= retired_d;
    end
  end

  assign cpu_en_o  = cpu_en;
  assign state_o   = state_q;
  assign cause_o   = cause_q;
  assign retired_o = retired_q;

endmodule

// File: doc/cpu_run_ctrl.md
CPU_RUN_CTRL -- requirements
Module: cpu_run_ctrl

Interface
REQ-001 Parameter CNT_W, default 32: width of retired-instruction counter.
REQ-002 Parameter EBREAK_HALT, default 1: 1 = EBREAK instruction halts the CPU; 0 = EBREAK executes as normal.
REQ-003 Port clk  input  1  single system clock, all state on rising edge.
REQ-004 Port rst  input  1  reset, asynchronous, active-low (0 = reset asserted).
REQ-005 Port run_i  input  1  level; 1 = free-run requested.
REQ-006 Port step_i  input  1  synchronous one-cycle pulse; request one instruction.
REQ-007 Port halt_i  input  1  synchronous pulse; external halt request.
REQ-008 Port resume_i  input  1  synchronous pulse; leave HALT.
REQ-009 Port pc_i  input  32  current PC of the datapath.
REQ-010 Port inst_i  input  32  instruction currently fetched at pc_i.
REQ-011 Port bp_en_i  input  1  breakpoint enable.
REQ-012 Port bp_addr_i  input  32  breakpoint PC.
REQ-013 Port cpu_en_o  output  1  datapath enable; PC, register file and data-memory writes advance only when 1.
REQ-014 Port state_o  output  2  current state encoding.
REQ-015 Port cause_o  output  2  halt cause: 0 none, 1 ebreak, 2 breakpoint, 3 external.
REQ-016 Port retired_o  output  CNT_W  count of cycles with cpu_en_o = 1.

Function
REQ-017 States SHALL be IDLE=0, RUN=1, STEP=2, HALT=3; state_o = current state.
REQ-018 is_ebrk SHALL be (inst_i == 32'h0010_0073) AND EBREAK_HALT; is_bp SHALL be bp_en_i AND pc_i == bp_addr_i AND NOT bp_skip.
REQ-019 cpu_en_o SHALL be combinational: 1 in RUN when NOT is_ebrk AND NOT is_bp AND NOT halt_i AND run_i; 1 in STEP when NOT is_ebrk; 0 otherwise.
REQ-020 IDLE: run_i=1 -> RUN; else step_i=1 -> STEP; else stay; run_i and step_i together -> RUN.
REQ-021 RUN, priority order: is_ebrk -> HALT cause 1; is_bp -> HALT cause 2; halt_i -> HALT cause 3; run_i=0 -> IDLE; else stay; step_i ignored.
REQ-022 STEP lasts exactly one cycle: is_ebrk -> HALT cause 1 (instruction not executed); else instruction executes, -> IDLE; breakpoint and halt_i ignored in STEP.
REQ-023 HALT: cpu_en_o = 0; resume_i with cause 2 or 3 -> IDLE and cause_o -> 0; resume_i with cause 1 ignored (only reset exits ebreak halt).
REQ-024 bp_skip SHALL set when entering HALT with cause 2 and clear after the first cycle with cpu_en_o = 1, so resume executes the breakpointed instruction once.
REQ-025 cause_o SHALL be registered, updated on HALT entry, held throughout HALT.
REQ-026 retired_o SHALL increment by 1 on every rising edge where cpu_en_o = 1, wrapping from 2^CNT_W-1 to 0 without flag.
REQ-027 Halting instruction SHALL never be partially executed: cpu_en_o is 0 in the cycle the halt condition is detected.
REQ-028 pc_i and inst_i change only when cpu_en_o was 1; block SHALL not depend on them outside RUN/STEP.

Reset
REQ-029 rst = 0 SHALL immediately force state IDLE, cpu_en_o = 0, cause_o = 0, bp_skip = 0, retired_o = 0, independent of clk.
REQ-030 Reset mid-RUN SHALL drop cpu_en_o in the same cycle; after rst release block waits in IDLE for run_i or step_i.

Structure
REQ-031 Package cpu_ctrl_pkg SHALL hold state enum, cause enum and EBREAK opcode constant.
REQ-032 Halt-condition compare (is_ebrk, is_bp) SHALL be a combinational sub-module cpu_halt_detect; FSM and counter stay in cpu_run_ctrl.

Verification
REQ-033 Reset, run_i=1, inst_i = NOP for 10 cycles -> state RUN, cpu_en_o = 1 each cycle, retired_o = 10.
REQ-034 RUN, bp_en_i=1, bp_addr_i=0x10, pc_i reaches 0x10 -> cpu_en_o = 0 that cycle, next state HALT, cause_o = 2; resume_i then run_i -> instruction at 0x10 executes once, no re-halt.
REQ-035 RUN, inst_i = 32'h0010_0073 -> HALT cause 1, retired_o frozen; resume_i ignored; rst low -> IDLE, cause 0, retired_o = 0.
REQ-036 IDLE, three step_i pulses 4 cycles apart -> exactly three single-cycle cpu_en_o pulses, retired_o = 3, state back to IDLE each time.
REQ-037 RUN with halt_i and breakpoint match in same cycle -> cause_o = 2 (priority); CNT_W=4 run 17 cycles -> retired_o = 1 (wrap).
REQ-038 rst asserted asynchronously mid-cycle during RUN -> cpu_en_o = 0 before next clk edge.
